debug_request_sequencer: RTL and testbench

Scheduler that shares the debug frame channel between several debug latch controllers. Each controller is selected by a 6-bit ID.
- On a start command, walks an ID range and pulses each ID onto the shared request-select bus.
- Captures the frame burst the selected controller streams out into an internal FIFO.
- Drains the FIFO to the TX interface over a valid/ready handshake.
Sits between the debug UART/interface FSM and the bank of latch controllers.

---
 rtl/debug_pkg.sv | 18 +
 rtl/debug_frame_fifo.sv | 55 +++++
 rtl/debug_request_sequencer.sv | 154 +++++++++++++++
 tb/tb_debug_request_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared constants and state encoding for the debug request sequencer.
package debug_pkg;

  localparam int unsigned NB_ID        = 6;
  localparam logic [NB_ID-1:0] IDLE_ID = '1;
  localparam int unsigned NB_HDR_INDEX = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SPACE,
    ST_ISSUE,
    ST_WAIT_START,
    ST_CAPTURE,
    ST_NEXT,
    ST_DRAIN
  } seq_state_t;

endpackage

// File: rtl/debug_frame_fifo.sv
// Synchronous frame FIFO; head is visible the cycle after a push into an empty FIFO.
module debug_frame_fifo #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned DEPTH   = 16
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic [NB_DATA-1:0]         i_data,
  input  logic                       i_pop,
  output logic [NB_DATA-1:0]         o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_free
);

  localparam int unsigned NB_PTR = $clog2(DEPTH);

  logic [NB_DATA-1:0] mem [DEPTH];
  logic [NB_PTR-1:0]  wr_ptr;
  logic [NB_PTR-1:0]  rd_ptr;
  logic [NB_PTR:0]    count;
  logic               do_push;
  logic               do_pop;

  assign o_empty = (count == '0);
  assign o_full  = (count == (NB_PTR+1)'(DEPTH));
  assign o_free  = (NB_PTR+1)'(DEPTH) - count;
  assign o_head  = o_empty ? '0 : mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a push onto a full FIFO is accepted.
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + NB_PTR'(1);
      if (do_pop)  rd_ptr <= rd_ptr + NB_PTR'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (NB_PTR+1)'(1);
        2'b01:   count <= count - (NB_PTR+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (do_push) mem[wr_ptr] <= i_data;
  end

endmodule

// File: rtl/debug_request_sequencer.sv
// Walks a controller-ID range, captures each controller's burst and drains it to TX.
// Build option DEBUG_SEQ_HEADER_EN prefixes every burst with an {id, 0, scan index} frame.
module debug_request_sequencer
  import debug_pkg::*;
#(
  parameter int unsigned NB_CONTROL_FRAME = 32,
  parameter int unsigned MAX_FRAMES       = 8,
  parameter int unsigned FIFO_DEPTH       = 16,
  parameter int unsigned NB_TIMEOUT       = 4
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic [NB_ID-1:0]            i_first_id,
  input  logic [NB_ID-1:0]            i_last_id,
  output logic [NB_ID-1:0]            o_request_select,
  input  logic [NB_CONTROL_FRAME-1:0] i_frame_from_latches,
  input  logic                        i_writing,
  output logic [NB_CONTROL_FRAME-1:0] o_frame_to_tx,
  output logic                        o_tx_valid,
  input  logic                        i_tx_ready,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_timeout_err,
  output logic                        o_overflow_err
);

  localparam int unsigned NB_FREE = $clog2(FIFO_DEPTH) + 1;
`ifdef DEBUG_SEQ_HEADER_EN
  localparam int unsigned REQ_FREE = MAX_FRAMES + 1;
`else
  localparam int unsigned REQ_FREE = MAX_FRAMES;
`endif

  seq_state_t                  state;
  logic [NB_ID-1:0]            cur_id;
  logic [NB_ID-1:0]            last_id;
  logic [NB_TIMEOUT-1:0]       timeout_cnt;
  logic                        fifo_push;
  logic                        fifo_pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [NB_FREE-1:0]          fifo_free;
  logic [NB_CONTROL_FRAME-1:0] push_data;
  logic                        capturing;

  assign capturing = i_writing & ((state == ST_WAIT_START) | (state == ST_CAPTURE));
  assign fifo_pop  = o_tx_valid & i_tx_ready;
  assign o_tx_valid = ~fifo_empty;
  assign o_busy     = (state != ST_IDLE) | ~fifo_empty;

`ifdef DEBUG_SEQ_HEADER_EN
  logic [NB_HDR_INDEX-1:0] scan_index;
  logic                    hdr_push;

  assign hdr_push  = (state == ST_ISSUE);
  assign fifo_push = capturing | hdr_push;
  assign push_data = hdr_push
                   ? {cur_id, {(NB_CONTROL_FRAME-NB_ID-NB_HDR_INDEX){1'b0}}, scan_index}
                   : i_frame_from_latches;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                                 scan_index <= '0;
    else if ((state == ST_IDLE) && i_start && !o_busy) scan_index <= '0;
    else if (hdr_push)                           scan_index <= scan_index + NB_HDR_INDEX'(1);
  end
`else
  assign fifo_push = capturing;
  assign push_data = i_frame_from_latches;
`endif

  debug_frame_fifo #(
    .NB_DATA (NB_CONTROL_FRAME),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (fifo_push),
    .i_data  (push_data),
    .i_pop   (fifo_pop),
    .o_head  (o_frame_to_tx),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_free  (fifo_free)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state            <= ST_IDLE;
      o_request_select <= IDLE_ID;
      cur_id           <= '0;
      last_id          <= '0;
      timeout_cnt      <= '0;
      o_done           <= 1'b0;
      o_timeout_err    <= 1'b0;
      o_overflow_err   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      // Set before the state case so a start in the same cycle clears it.
      if (fifo_push && fifo_full && !fifo_pop) o_overflow_err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (i_start && !o_busy) begin
            cur_id         <= i_first_id;
            last_id        <= i_last_id;
            o_timeout_err  <= 1'b0;
            o_overflow_err <= 1'b0;
            state          <= ST_WAIT_SPACE;
          end
        end
        ST_WAIT_SPACE: begin
          if (fifo_free >= NB_FREE'(REQ_FREE)) begin
            o_request_select <= cur_id;
            state            <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          o_request_select <= IDLE_ID;
          timeout_cnt      <= '0;
          state            <= ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (i_writing) begin
            state <= ST_CAPTURE;
          end else if (timeout_cnt == '1) begin
            o_timeout_err <= 1'b1;
            state         <= ST_NEXT;
          end else begin
            timeout_cnt <= timeout_cnt + NB_TIMEOUT'(1);
          end
        end
        ST_CAPTURE: begin
          if (!i_writing) state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (cur_id == last_id) begin
            state <= ST_DRAIN;
          end else begin
            cur_id <= cur_id + NB_ID'(1);
            state  <= ST_WAIT_SPACE;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            o_done <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_request_sequencer.sv
// Bench for debug_request_sequencer: queue-based FIFO/scan model, model latch controllers, directed scans.
module tb_debug_request_sequencer;

  localparam int DEPTH = 16;
  localparam logic [5:0] IDLE = 6'h3F;
`ifdef DEBUG_SEQ_HEADER_EN
  localparam int REQ   = 9;
  localparam int NHDR  = 1;
  logic [31:0] t2_exp [9] = '{32'h0000_0000, 32'h00, 32'h01,
                              32'h0400_0001, 32'h10, 32'h11,
                              32'h0800_0002, 32'h20, 32'h21};
`else
  localparam int REQ   = 8;
  localparam int NHDR  = 0;
  logic [31:0] t2_exp [6] = '{32'h00, 32'h01, 32'h10, 32'h11, 32'h20, 32'h21};
`endif

  logic        i_clock, i_reset, i_start, i_writing, i_tx_ready;
  logic [5:0]  i_first_id, i_last_id, o_request_select;
  logic [31:0] i_frame_from_latches, o_frame_to_tx;
  logic        o_tx_valid, o_busy, o_done, o_timeout_err, o_overflow_err;

  debug_request_sequencer #(
    .NB_CONTROL_FRAME (32),
    .MAX_FRAMES       (8),
    .FIFO_DEPTH       (DEPTH),
    .NB_TIMEOUT       (4)
  ) dut (
    .i_clock              (i_clock),
    .i_reset              (i_reset),
    .i_start              (i_start),
    .i_first_id           (i_first_id),
    .i_last_id            (i_last_id),
    .o_request_select     (o_request_select),
    .i_frame_from_latches (i_frame_from_latches),
    .i_writing            (i_writing),
    .o_frame_to_tx        (o_frame_to_tx),
    .o_tx_valid           (o_tx_valid),
    .i_tx_ready           (i_tx_ready),
    .o_busy               (o_busy),
    .o_done               (o_done),
    .o_timeout_err        (o_timeout_err),
    .o_overflow_err       (o_overflow_err)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int          tests, fails, cyc, done_cnt, e_id;
  logic [31:0] mq[$];
  logic [31:0] tx_log[$];
  int          exp_ids[$];
  int          issue_log[$];
  bit          m_ovf, start_ok, pend_valid, prev_done;
  logic [31:0] pend_head;
  logic [5:0]  sel_neg, prev_sel;
  logic [7:0]  m_idx;
  int          nfr [64];
  logic [31:0] base [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_push(input logic [31:0] v);
    if (mq.size() >= DEPTH) m_ovf = 1'b1;
    else mq.push_back(v);
  endtask

  // Reference model: FIFO contents as a queue, updated on each clock edge.
  always @(posedge i_clock) begin
    cyc++;
    if (i_reset) begin
      mq.delete();
      m_ovf = 1'b0;
      m_idx = 8'd0;
    end else begin
      if (pend_valid && i_tx_ready) tx_log.push_back(pend_head);
      if (mq.size() != 0 && i_tx_ready) void'(mq.pop_front());
      if (start_ok && i_start) begin
        m_ovf = 1'b0;
        m_idx = 8'd0;
      end
`ifdef DEBUG_SEQ_HEADER_EN
      if (sel_neg != IDLE) begin
        model_push({sel_neg, 18'b0, m_idx});
        m_idx = m_idx + 8'd1;
      end
`endif
      if (i_writing) model_push(i_frame_from_latches);
    end
  end

  // Per-cycle compare against the model.
  always @(negedge i_clock) begin
    if (i_reset) begin
      sel_neg = IDLE; prev_sel = IDLE; pend_valid = 1'b0; prev_done = 1'b0;
    end else begin
      chk("tx_valid", 32'(o_tx_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("tx_head", o_frame_to_tx, mq[0]);
      chk("overflow_flag", 32'(o_overflow_err), 32'(m_ovf));
      if (o_request_select != IDLE) begin
        issue_log.push_back(int'(o_request_select));
        if (exp_ids.size() == 0) begin
          tests++; fails++;
          $display("FAIL issue_extra: got id %0d, required no further issue", o_request_select);
        end else begin
          e_id = exp_ids.pop_front();
          chk("issue_id", 32'(o_request_select), 32'(e_id));
        end
        chk("issue_gap", 32'(prev_sel), 32'(IDLE));
        chk("issue_space", 32'((DEPTH - mq.size()) >= REQ), 32'd1);
      end
      if (prev_sel != IDLE) chk("select_pulse", 32'(o_request_select), 32'(IDLE));
      if (prev_done) chk("done_pulse", 32'(o_done), 32'd0);
      if (o_done) begin
        done_cnt++;
        chk("done_drained", 32'(mq.size()), 32'd0);
        chk("done_all_issued", 32'(exp_ids.size()), 32'd0);
      end
      prev_done  = o_done;
      prev_sel   = o_request_select;
      sel_neg    = o_request_select;
      pend_valid = o_tx_valid;
      pend_head  = o_frame_to_tx;
    end
  end

  // Model latch controllers: fresh select edge -> burst of nfr[id] frames 2 cycles later.
  initial begin : ctrl_model
    logic [5:0] c_prev, c_id;
    int start_c, rem, j;
    i_writing = 1'b0; i_frame_from_latches = '0;
    c_prev = IDLE; c_id = '0; start_c = 0; rem = 0; j = 0;
    forever begin
      @(negedge i_clock); #1;
      if (i_reset) begin
        rem = 0; c_prev = IDLE; i_writing = 1'b0; i_frame_from_latches = '0;
      end else begin
        if (o_request_select != IDLE && o_request_select != c_prev) begin
          c_id = o_request_select; start_c = cyc + 2; rem = nfr[c_id]; j = 0;
        end
        c_prev = o_request_select;
        if (rem > 0 && cyc >= start_c) begin
          i_writing = 1'b1; i_frame_from_latches = base[c_id] + 32'(j); j++; rem--;
        end else begin
          i_writing = 1'b0; i_frame_from_latches = '0;
        end
      end
    end
  end

  task automatic cfg_clear();
    for (int i = 0; i < 64; i++) begin nfr[i] = 0; base[i] = '0; end
  endtask

  task automatic start_scan(input logic [5:0] f, input logic [5:0] l);
    logic [5:0] id;
    exp_ids.delete(); issue_log.delete(); tx_log.delete();
    id = f;
    forever begin
      if (id != IDLE) exp_ids.push_back(int'(id));
      if (id == l) break;
      id = id + 6'd1;
    end
    @(negedge i_clock); #1;
    i_first_id = f; i_last_id = l; i_start = 1'b1; start_ok = 1'b1;
    @(negedge i_clock); #1;
    i_start = 1'b0; start_ok = 1'b0;
    chk("busy_after_start", 32'(o_busy), 32'd1);
    chk("errors_cleared", 32'({o_timeout_err, o_overflow_err}), 32'd0);
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0, k;
    d0 = done_cnt; k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge i_clock); #2; k++;
    end
    chk(name, 32'(done_cnt - d0), 32'd1);
    chk("busy_end", 32'(o_busy), 32'd0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "bench time limit reached");
  end

  initial begin : main
    int k;
    bit found;
    tests = 0; fails = 0; cyc = 0; done_cnt = 0;
    i_reset = 1'b1; i_start = 1'b0; i_first_id = '0; i_last_id = '0;
    i_tx_ready = 1'b0; start_ok = 1'b0; m_ovf = 1'b0; m_idx = '0;
    cfg_clear();
    repeat (3) @(negedge i_clock);
    #1;
    chk("rst_select", 32'(o_request_select), 32'h3F);
    chk("rst_frame", o_frame_to_tx, 32'h0);
    chk("rst_flags", 32'({o_tx_valid, o_busy, o_done, o_timeout_err, o_overflow_err}), 32'd0);
    i_reset = 1'b0;

    // Single ID
    cfg_clear(); nfr[3] = 1; base[3] = 32'hDEADBEEF; i_tx_ready = 1'b1;
    start_scan(6'd3, 6'd3);
    wait_done(100, "t1_done");
    chk("t1_beats", 32'(tx_log.size()), 32'(1 + NHDR));
    chk("t1_data", tx_log[tx_log.size()-1], 32'hDEADBEEF);
    chk("t1_timeout", 32'(o_timeout_err), 32'd0);
`ifdef DEBUG_SEQ_HEADER_EN
    chk("t1_header", tx_log[0], 32'h0C00_0000);
`endif

    // Range 0..2, with a start pulse while busy that must be ignored
    cfg_clear();
    for (int i = 0; i < 3; i++) begin nfr[i] = 2; base[i] = 32'(i * 16); end
    start_scan(6'd0, 6'd2);
    repeat (6) @(negedge i_clock);
    #1; i_first_id = 6'd40; i_last_id = 6'd41; i_start = 1'b1;
    @(negedge i_clock); #1; i_start = 1'b0;
    wait_done(300, "t2_done");
    chk("t2_count", 32'(tx_log.size()), 32'($size(t2_exp)));
    for (int i = 0; i < $size(t2_exp); i++) chk("t2_beat", tx_log[i], t2_exp[i]);
    chk("t2_issues", 32'(issue_log.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("t2_issue_order", 32'(issue_log[i]), 32'(i));

    // Backpressure: FIFO fills, third ID must wait for space
    cfg_clear();
    for (int i = 0; i < 4; i++) begin nfr[i] = 8; base[i] = 32'(i << 8); end
    i_tx_ready = 1'b0;
    start_scan(6'd0, 6'd3);
    repeat (80) @(negedge i_clock);
    #1;
    chk("t3_held", 32'(issue_log.size()), 32'(2 - NHDR));
    chk("t3_valid", 32'(o_tx_valid), 32'd1);
    i_tx_ready = 1'b1;
    wait_done(500, "t3_done");
    chk("t3_count", 32'(tx_log.size()), 32'(32 + 4 * NHDR));
    chk("t3_first", tx_log[NHDR], 32'h0000_0000);
    chk("t3_last", tx_log[tx_log.size()-1], 32'h0000_0307);
    chk("t3_overflow", 32'(o_overflow_err), 32'd0);

    // Timeout on ID 5, scan continues to ID 6
    cfg_clear(); nfr[6] = 1; base[6] = 32'h600;
    start_scan(6'd5, 6'd6);
    wait_done(200, "t4_done");
    chk("t4_timeout", 32'(o_timeout_err), 32'd1);
    chk("t4_last", tx_log[tx_log.size()-1], 32'h600);
    chk("t4_count", 32'(tx_log.size()), 32'(1 + 2 * NHDR));

`ifndef DEBUG_SEQ_HEADER_EN
    // Wrapping range 62..1 passes through IDLE_ID, which times out
    cfg_clear();
    nfr[62] = 1; base[62] = 32'h1000; nfr[0] = 1; base[0] = 32'h2000; nfr[1] = 1; base[1] = 32'h3000;
    start_scan(6'd62, 6'd1);
    wait_done(300, "t5_done");
    chk("t5_timeout", 32'(o_timeout_err), 32'd1);
    chk("t5_count", 32'(tx_log.size()), 32'd3);
    chk("t5_beat0", tx_log[0], 32'h1000);
    chk("t5_beat1", tx_log[1], 32'h2000);
    chk("t5_beat2", tx_log[2], 32'h3000);
    chk("t5_issue0", 32'(issue_log[0]), 32'd62);
`endif

    // Overflow: burst longer than FIFO, then push+pop while full
    cfg_clear(); nfr[7] = 20; base[7] = 32'h7000; i_tx_ready = 1'b0;
    start_scan(6'd7, 6'd7);
    k = 0;
    while (!o_overflow_err && k < 100) begin @(negedge i_clock); #2; k++; end
    chk("t6_overflow_set", 32'(o_overflow_err), 32'd1);
    i_tx_ready = 1'b1;
    wait_done(200, "t6_done");
    chk("t6_sticky", 32'(o_overflow_err), 32'd1);
    chk("t6_count", 32'(tx_log.size()), 32'(19 + NHDR));
    chk("t6_last", tx_log[tx_log.size()-1], 32'h7013);

    // Reset during capture of the second frame
    cfg_clear(); nfr[0] = 3; base[0] = 32'h8000; nfr[1] = 3; base[1] = 32'h8100; i_tx_ready = 1'b0;
    start_scan(6'd0, 6'd1);
    found = 1'b0; k = 0;
    while (!found && k < 50) begin
      @(negedge i_clock); #2; k++;
      found = i_writing && (i_frame_from_latches == 32'h8001);
    end
    chk("t7_found", 32'(found), 32'd1);
    chk("t7_valid_before", 32'(o_tx_valid), 32'd1);
    i_reset = 1'b1; #1;
    chk("t7_select", 32'(o_request_select), 32'h3F);
    chk("t7_valid", 32'(o_tx_valid), 32'd0);
    chk("t7_busy", 32'(o_busy), 32'd0);
    repeat (2) @(negedge i_clock);
    #1; exp_ids.delete(); i_reset = 1'b0;
    repeat (3) @(negedge i_clock);
    #1;
    chk("t7_idle", 32'({o_busy, o_tx_valid, o_timeout_err, o_overflow_err}), 32'd0);

    // Recovery scan after reset (header check when enabled)
    cfg_clear(); nfr[4] = 1; base[4] = 32'hCAFE0004; i_tx_ready = 1'b1;
    start_scan(6'd4, 6'd4);
    wait_done(100, "t8_done");
    chk("t8_count", 32'(tx_log.size()), 32'(1 + NHDR));
    chk("t8_data", tx_log[tx_log.size()-1], 32'hCAFE0004);
`ifdef DEBUG_SEQ_HEADER_EN
    chk("t8_header", tx_log[0], 32'h1000_0000);
`endif

    repeat (3) @(negedge i_clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
